// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
// Optional signed-overflow output is enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Full-subtractor cell; returns {bout, di}.
    function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic bin);
        logic di;
        logic bout;
        di   = ai ^ bi ^ bin;
        bout = (~ai & bi) | (~(ai ^ bi) & bin);
        return {bout, di};
    endfunction

    state_t             state_r, state_nxt_s;
    logic [WIDTH-1:0]   a_sh_r, a_sh_nxt_s;
    logic [WIDTH-1:0]   b_sh_r, b_sh_nxt_s;
    logic [WIDTH-1:0]   res_sh_r, res_sh_nxt_s;
    logic               borrow_r, borrow_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0]   diff_r, diff_nxt_s;
    logic               borrow_out_r, borrow_out_nxt_s;
    logic               done_r, done_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               a_msb_r, a_msb_nxt_s;
    logic               b_msb_r, b_msb_nxt_s;
    logic               ovf_r, ovf_nxt_s;
    logic [1:0]         cell_s;

    assign cell_s = full_sub(a_sh_r[0], b_sh_r[0], borrow_r);

    // Next-state and datapath update logic.
    always_comb begin
        state_nxt_s      = state_r;
        a_sh_nxt_s       = a_sh_r;
        b_sh_nxt_s       = b_sh_r;
        res_sh_nxt_s     = res_sh_r;
        borrow_nxt_s     = borrow_r;
        cnt_nxt_s        = cnt_r;
        diff_nxt_s       = diff_r;
        borrow_out_nxt_s = borrow_out_r;
        done_nxt_s       = 1'b0;
        busy_nxt_s       = busy_r;
        a_msb_nxt_s      = a_msb_r;
        b_msb_nxt_s      = b_msb_r;
        ovf_nxt_s        = ovf_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    a_sh_nxt_s   = a;
                    b_sh_nxt_s   = b;
                    a_msb_nxt_s  = a[WIDTH-1];
                    b_msb_nxt_s  = b[WIDTH-1];
                    res_sh_nxt_s = {WIDTH{1'b0}};
                    borrow_nxt_s = 1'b0;
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    busy_nxt_s   = 1'b1;
                    state_nxt_s  = RUN;
                end else begin
                    busy_nxt_s   = 1'b0;
                    state_nxt_s  = IDLE;
                end
            end
            RUN: begin
                res_sh_nxt_s = {cell_s[0], res_sh_r[WIDTH-1:1]};
                a_sh_nxt_s   = {1'b0, a_sh_r[WIDTH-1:1]};
                b_sh_nxt_s   = {1'b0, b_sh_r[WIDTH-1:1]};
                borrow_nxt_s = cell_s[1];
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    // Last bit: publish the full result in one step, never partially.
                    diff_nxt_s       = {cell_s[0], res_sh_r[WIDTH-1:1]};
                    borrow_out_nxt_s = cell_s[1];
                    ovf_nxt_s        = (a_msb_r != b_msb_r) && (cell_s[0] != a_msb_r);
                    done_nxt_s       = 1'b1;
                    busy_nxt_s       = 1'b0;
                    state_nxt_s      = IDLE;
                end else begin
                    cnt_nxt_s        = cnt_r + CNT_W'(1);
                    busy_nxt_s       = 1'b1;
                    state_nxt_s      = RUN;
                end
            end
            default: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            a_sh_r       <= {WIDTH{1'b0}};
            b_sh_r       <= {WIDTH{1'b0}};
            res_sh_r     <= {WIDTH{1'b0}};
            borrow_r     <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            diff_r       <= {WIDTH{1'b0}};
            borrow_out_r <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            a_msb_r      <= 1'b0;
            b_msb_r      <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            a_sh_r       <= a_sh_nxt_s;
            b_sh_r       <= b_sh_nxt_s;
            res_sh_r     <= res_sh_nxt_s;
            borrow_r     <= borrow_nxt_s;
            cnt_r        <= cnt_nxt_s;
            diff_r       <= diff_nxt_s;
            borrow_out_r <= borrow_out_nxt_s;
            done_r       <= done_nxt_s;
            busy_r       <= busy_nxt_s;
            a_msb_r      <= a_msb_nxt_s;
            b_msb_r      <= b_msb_nxt_s;
            ovf_r        <= ovf_nxt_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign diff       = diff_r;
    assign borrow_out = borrow_out_r;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign overflow = ovf_r;
`else
    logic unused_ovf_s;
    assign unused_ovf_s = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         overflow;
`endif

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive start for one cycle at a negedge; returns after the accepting edge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count cycles to done; optionally require diff to hold a value meanwhile.
    task automatic wait_done(output int cyc, input bit hold_chk, input logic [W-1:0] hold_val);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            if (hold_chk && diff !== hold_val) begin
                bad++; total++;
                $display("FAIL hold: got %0d expected %0d", diff, hold_val);
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int extra;
        vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0, 1'b0};
        vecs[1] = '{8'd5,   8'd9,   8'd252, 1'b1, 1'b0};
        vecs[2] = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b0};
        vecs[3] = '{8'd255, 8'd255, 8'd0,   1'b0, 1'b0};
        vecs[4] = '{8'd0,   8'd1,   8'd255, 1'b1, 1'b0};
        vecs[5] = '{8'd255, 8'd0,   8'd255, 1'b0, 1'b0};
        vecs[6] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
        vecs[7] = '{8'h10,  8'h01,  8'h0F,  1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_borrow", 64'(borrow_out), 64'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("rst_ovf", 64'(overflow), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
            wait_done(cyc, 1'b0, 8'd0);
            chk($sformatf("v%0d_lat", i), 64'(cyc), 64'd8);
            chk($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'd0);
            chk($sformatf("v%0d_diff", i), 64'(diff), 64'(vecs[i].d));
            chk($sformatf("v%0d_borrow", i), 64'(borrow_out), 64'(vecs[i].bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].ov));
`endif
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
        end

        // start and operand changes during RUN must be ignored
        issue(8'd100, 8'd30);
        @(negedge clk); @(negedge clk);
        a = 8'd7; b = 8'd99; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'd1; b = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, 1'b0, 8'd0);
        chk("ign_lat", 64'(cyc + 5), 64'd8);
        chk("ign_diff", 64'(diff), 64'd70);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        chk("ign_no_second", 64'(extra), 64'd0);

        // back-to-back: new start in the done cycle
        issue(8'd100, 8'd30);
        wait_done(cyc, 1'b0, 8'd0);
        chk("b2b_first", 64'(diff), 64'd70);
        issue(8'd17, 8'd18);
        wait_done(cyc, 1'b1, 8'd70);
        chk("b2b_lat", 64'(cyc), 64'd8);
        chk("b2b_diff", 64'(diff), 64'd255);
        chk("b2b_borrow", 64'(borrow_out), 64'd1);

        // reset mid-operation aborts with no done
        @(negedge clk);
        issue(8'd50, 8'd20);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_diff", 64'(diff), 64'd0);
        chk("abort_borrow", 64'(borrow_out), 64'd0);
        extra = 0;
        repeat (12) begin
            if (done === 1'b1) extra++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(extra), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
